// File: rtl/seq_producer_pkg.sv
// Shared types and constants for the sequence producer slice.
package seq_producer_pkg;

    // Operating mode; the encoding is also driven straight onto the mode port.
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_FIB   = 2'b01,
        MODE_TIMER = 2'b10
    } mode_t;

    // Fibonacci seed pair (a, b); a is the next term to be emitted.
    localparam int unsigned FIB_A0 = 0;
    localparam int unsigned FIB_B0 = 1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a registered head word.
// Optional macro PARITY_EN: when defined, a parity bit is registered alongside
// the head word; otherwise parity is tied low.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       parity,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q, rd_nxt;
    logic [LVL_W-1:0] level_q, level_nxt;
    logic [WIDTH-1:0] head_q, head_nxt;
    logic             pop;

    // Next pointers, occupancy and head word; a push into the slot that
    // becomes the head bypasses the array.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        pop       = (level_q != '0) && ready;
        rd_nxt    = rd_q + PTR_W'(pop);
        level_nxt = level_q + LVL_W'(push) - LVL_W'(pop);
        head_nxt  = head_q;
        if (level_nxt != '0) begin
            if (push && (wr_q == rd_nxt)) head_nxt = wdata;
            else                          head_nxt = mem[rd_nxt];
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; only words covered by level are ever observed.
    always_ff @(posedge clock) begin
        if (push) mem[wr_q] <= wdata;
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_q + PTR_W'(push);
            rd_q    <= rd_nxt;
            level_q <= level_nxt;
            head_q  <= head_nxt;
        end
    end

`ifdef PARITY_EN
    logic parity_q;

    // Parity registered in the same cycle as the head word it covers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) parity_q <= 1'b0;
        else        parity_q <= ^head_nxt;
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

    assign dout       = head_q;
    assign dout_valid = (level_q != '0);
    assign level      = level_q;
    assign full       = (level_q == LVL_W'(DEPTH));

endmodule

// File: rtl/seq_producer_buf.sv
// Fibonacci / timer sequence producer feeding a FWFT FIFO, with programmable
// production rate and back-pressure from the consumer.
// Optional macro PARITY_EN (handled inside sync_fifo_fwft) enables dout parity.
module seq_producer_buf
    import seq_producer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int BASE_DIV = 1,
    parameter int PROG_W   = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_f,
    input  logic                       start_t,
    input  logic                       stop_f_t,
    input  logic                       update,
    input  logic [PROG_W-1:0]          prog,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       parity,
    output logic [1:0]                 mode,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(BASE_DIV + 1) + (1 << PROG_W);

    mode_t             state_q, state_d;
    logic [PROG_W-1:0] prog_q;
    logic [CNT_W-1:0]  cnt_q, period;
    logic [WIDTH-1:0]  fib_a_q, fib_b_q, timer_q, pend_val_q;
    logic              fib_wrap_q, pend_q, overrun_q;
    logic [WIDTH:0]    fib_sum;
    logic [WIDTH-1:0]  gen_val, push_data;
    logic              start_any, running, tick, push_req, push_ok, push;

    // Mode transitions: stop beats start_f, which beats start_t.
    always_comb begin
        state_d = state_q;
        if (stop_f_t)     state_d = MODE_IDLE;
        else if (start_f) state_d = MODE_FIB;
        else if (start_t) state_d = MODE_TIMER;
    end

    // Mode register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= MODE_IDLE;
        else        state_q <= state_d;
    end

    // Rate tick, generator output and push arbitration; control pulses
    // suppress the tick so a (re)start or rate change begins a fresh period.
    always_comb begin
        start_any = !stop_f_t && (start_f || start_t);
        running   = (state_q != MODE_IDLE);
        period    = CNT_W'(BASE_DIV) << prog_q;
        tick      = running && !pend_q && !stop_f_t && !start_any && !update
                    && (cnt_q == period - CNT_W'(1));
        fib_sum   = {1'b0, fib_a_q} + {1'b0, fib_b_q};
        gen_val   = (state_q == MODE_FIB) ? fib_a_q : timer_q;
        push_data = pend_q ? pend_val_q : gen_val;
        push_ok   = !full || (dout_valid && dout_ready);
        push_req  = !stop_f_t && !start_any && (tick || pend_q);
        push      = push_req && push_ok;
    end

    // Rate select and tick counter; the counter freezes while a value is pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prog_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (update) prog_q <= prog;
            if (stop_f_t || start_any || update || tick) cnt_q <= '0;
            else if (running && !pend_q)                 cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Sequence generators; an overflowing Fibonacci sum restarts at 0,1 after
    // the last representable term has been emitted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fib_a_q    <= WIDTH'(FIB_A0);
            fib_b_q    <= WIDTH'(FIB_B0);
            fib_wrap_q <= 1'b0;
            timer_q    <= '0;
        end else if (start_any) begin
            fib_a_q    <= WIDTH'(FIB_A0);
            fib_b_q    <= WIDTH'(FIB_B0);
            fib_wrap_q <= 1'b0;
            timer_q    <= '0;
        end else if (tick) begin
            if (state_q == MODE_FIB) begin
                if (fib_wrap_q) begin
                    fib_a_q    <= WIDTH'(FIB_A0);
                    fib_b_q    <= WIDTH'(FIB_B0);
                    fib_wrap_q <= 1'b0;
                end else begin
                    fib_a_q    <= fib_b_q;
                    fib_b_q    <= fib_sum[WIDTH-1:0];
                    fib_wrap_q <= fib_sum[WIDTH];
                end
            end else begin
                timer_q <= timer_q + WIDTH'(1);
            end
        end
    end

    // Pending slot for a value the full FIFO could not take, plus the sticky
    // overrun flag (a tick landing on an occupied slot).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= overrun_q | (tick && pend_q);
            if (stop_f_t || start_any) begin
                pend_q <= 1'b0;
            end else if (push) begin
                pend_q <= 1'b0;
            end else if (tick) begin
                pend_q     <= 1'b1;
                pend_val_q <= gen_val;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .wdata      (push_data),
        .ready      (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .parity     (parity),
        .level      (level),
        .full       (full)
    );

    assign mode    = state_q;
    assign overrun = overrun_q;

endmodule

// File: doc/seq_producer_buf.md
Name: seq_producer_buf

Overview:
Parametrised next-generation sequence producer for the producer/consumer path. Generates a Fibonacci or timer (up-count) sequence at a programmable rate and pushes each value into an internal FIFO. The consumer drains the FIFO over a valid/ready interface, so producer and consumer can run at independent rates and a full FIFO back-pressures the producer without loss. Sits between the control pushbuttons and the display/consumer logic.

Parameters:
WIDTH, 8, data width of generated values
DEPTH, 4, FIFO depth in words (power of 2, >=2)
BASE_DIV, 1, base production period in clocks; effective period = BASE_DIV << prog_q
PROG_W, 3, width of the rate-select field

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start_f  in  1  one-cycle pulse: start Fibonacci mode
start_t  in  1  one-cycle pulse: start timer mode
stop_f_t  in  1  one-cycle pulse: stop production
update  in  1  one-cycle pulse: latch prog
prog  in  PROG_W  rate select, sampled on update
dout  out  WIDTH  FIFO head value
dout_valid  out  1  head valid
dout_ready  in  1  consumer accepts head
parity  out  1  even parity of dout (see Optional Feature)
mode  out  2  00 idle, 01 Fibonacci, 10 timer
level  out  $clog2(DEPTH)+1  FIFO occupancy
full  out  1  level == DEPTH
overrun  out  1  sticky: a tick occurred while a value was already pending

Behaviour:
- Reset (asynchronous, active-low): state IDLE, prog_q=0, tick counter 0, fib regs a=0 b=1, timer 0, FIFO empty. dout=0, dout_valid=0, parity=0, mode=00, level=0, full=0, overrun=0.
- States: IDLE, FIB, TIMER. start_f -> FIB; start_t -> TIMER (from any state, including restart of the same mode). stop_f_t -> IDLE.
- Priority on same cycle: stop_f_t > start_f > start_t.
- Each start clears the tick counter and reinitialises the sequence: FIB emits 0,1,1,2,3,5...; TIMER emits 0,1,2...
- Period P = BASE_DIV << prog_q. The tick fires at the P-th edge after the start edge. Each tick generates the next value.
- Push: the value is written on the tick edge if the FIFO is not full. Otherwise it is held pending and written on the first edge with the FIFO not full. The tick counter freezes while a value is pending.
- A tick with a value already pending sets overrun. This occurs only if the counter is not frozen and is treated as a design error flag; overrun clears only on reset.
- FIB wrap: if a+b exceeds 2^WIDTH-1, the value following the largest representable term is 0 and the sequence restarts at 0,1. For WIDTH=8: ...144, 233, 0, 1, 1...
- TIMER wrap: 2^WIDTH-1 -> 0.
- update: prog_q <= prog and the tick counter is cleared. Allowed in any state; takes effect for the next period.
- stop_f_t: production halts and any pending value is discarded. FIFO contents are retained and remain drainable.
- FIFO is first-word-fall-through: dout_valid rises the edge after the push into an empty FIFO. Pop happens when dout_valid && dout_ready. Simultaneous push and pop when full is accepted (level unchanged).
- dout holds its last value when empty; dout_valid=0.

Optional Feature:
PARITY_EN
- Defined: parity = ^dout, registered together with dout (same cycle).
- Undefined: parity tied to 0 and no parity logic is generated.

Decomposition:
- Package seq_producer_pkg: mode enum (MODE_IDLE=2'b00, MODE_FIB=2'b01, MODE_TIMER=2'b10), FIB initial constants.
- Sub-module sync_fifo_fwft(WIDTH, DEPTH): pointers, level, full/empty, FWFT head register.
- seq_producer_buf contains the FSM, rate counter and generators.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4, BASE_DIV=1.
1. Reset low mid-operation -> all outputs zero immediately, without waiting for a clock edge; mode=00.
2. update prog=3 (P=8), start_f, dout_ready=1 -> dout sequence 0,1,1,2,3,5 with pushes every 8 clocks.
3. prog=0, start_t, dout_ready=0 -> level reaches 4, full=1, counter frozen. Raise ready -> drain yields 0,1,2,3,4,... with no gaps or drops.
4. Fibonacci run to wrap -> values ...144,233,0,1,1; no X or truncated sum.
5. start_f and stop_f_t on the same cycle -> mode stays 00 and nothing is pushed. start_f and start_t together -> mode=01.
6. With PARITY_EN: dout=8'h07 -> parity=1; dout=8'h03 -> parity=0. Without PARITY_EN: parity=0 always.
